// File: rtl/audio_pkg.sv
// Shared I2S framing constants, frame payload type and sample conversion.
package audio_pkg;

    localparam int unsigned I2S_SLOTS   = 32;
    localparam int unsigned I2S_CH_BITS = 16;
    localparam int unsigned SLOT_W      = $clog2(I2S_SLOTS);
    localparam int unsigned FRAME_W     = 2 * I2S_CH_BITS;

    // One stereo frame as shifted out: left word first, MSB first.
    typedef struct packed {
        logic [I2S_CH_BITS-1:0] left;
        logic [I2S_CH_BITS-1:0] right;
    } i2s_frame_t;

    // Offset-binary sample of width w (zero-extended in u) to a left-justified
    // two's-complement channel word; flipping the MSB recentres the midpoint on 0.
    function automatic logic [I2S_CH_BITS-1:0] to_s16(input logic [31:0] u,
                                                      input int unsigned w);
        logic [31:0] flipped;
        flipped = u ^ (32'(1) << (w - 1));
        if (w >= I2S_CH_BITS)
            return I2S_CH_BITS'(flipped >> (w - I2S_CH_BITS));
        else
            return I2S_CH_BITS'(flipped << (I2S_CH_BITS - w));
    endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// I2S bit-clock divider.
//   clk, rst_n : system clock, async active-low reset
//   bclk       : registered bit clock, period 2*BCLK_DIV clk cycles
//   rise_c     : high in the cycle whose edge drives bclk 0->1
//   fall_c     : high in the cycle whose edge drives bclk 1->0
module i2s_bclk_div #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt;
    logic             terminal_c;

    assign terminal_c = (cnt == CNT_W'(BCLK_DIV - 1));
    assign rise_c     = terminal_c & ~bclk;
    assign fall_c     = terminal_c & bclk;

    // Half-period counter; bclk toggles at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (terminal_c) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono sample to stereo I2S transmitter (L = R).
//   clk, rst_n   : system clock, async active-low reset
//   in_sample    : unsigned mono sample, midpoint 2^(SAMPLE_W-1)
//   in_valid     : in_sample valid this cycle
//   in_ready     : block accepts in_sample this cycle
//   i2s_bclk     : bit clock
//   i2s_lrclk    : word select, 0 = left
//   i2s_sdata    : serial data, MSB first, one-BCLK delay after lrclk
//   underrun_cnt : saturating count of frames loaded with no new sample
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 10,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic [7:0]          underrun_cnt
);

    logic              bclk_rise_c;
    logic              bclk_fall_c;

    logic [SLOT_W-1:0] slot,      slot_nxt;
    i2s_frame_t        frame,     frame_nxt;
    logic [SAMPLE_W-1:0] hold,    hold_nxt;
    logic              pending,   pending_nxt;
    logic              lrclk_nxt;
    logic              sdata_nxt;
    logic [7:0]        underrun_nxt;

    logic              load_c;
    logic              accept_c;
    logic [FRAME_W-1:0] frame_bits_c;
    logic [I2S_CH_BITS-1:0] hold_s16_c;
    logic [I2S_CH_BITS-1:0] in_s16_c;

    i2s_bclk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .bclk   (i2s_bclk),
        .rise_c (bclk_rise_c),
        .fall_c (bclk_fall_c)
    );

    // The divider must never signal both edges in one cycle.
    strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(bclk_rise_c && bclk_fall_c));

    assign hold_s16_c = to_s16(32'(hold), SAMPLE_W);
    assign in_s16_c   = to_s16(32'(in_sample), SAMPLE_W);
    assign accept_c   = in_valid & in_ready;
    // Entering slot 1: the new left MSB goes out on this edge.
    assign load_c     = bclk_fall_c & (slot == '0);

    // Next-state for slot, frame, holding register and serial outputs.
    always_comb begin
        slot_nxt     = slot;
        frame_nxt    = frame;
        hold_nxt     = hold;
        pending_nxt  = pending;
        lrclk_nxt    = i2s_lrclk;
        sdata_nxt    = i2s_sdata;
        underrun_nxt = underrun_cnt;
        frame_bits_c = '0;

        if (load_c) begin
            if (pending) begin
                frame_nxt   = '{left: hold_s16_c, right: hold_s16_c};
                pending_nxt = 1'b0;
            end else if (in_valid) begin
                frame_nxt   = '{left: in_s16_c, right: in_s16_c};
            end else if (underrun_cnt != 8'hFF) begin
                underrun_nxt = underrun_cnt + 8'd1;
            end
        end else if (accept_c) begin
            hold_nxt    = in_sample;
            pending_nxt = 1'b1;
        end

        if (bclk_fall_c) begin
            slot_nxt     = slot + SLOT_W'(1);
            lrclk_nxt    = (slot_nxt >= SLOT_W'(I2S_SLOTS / 2));
            // Slot n carries frame bit for slot n-1, i.e. index 31-(n-1) = ~slot.
            frame_bits_c = frame_nxt;
            sdata_nxt    = frame_bits_c[~slot];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= '0;
            frame        <= '0;
            hold         <= '0;
            pending      <= 1'b0;
            in_ready     <= 1'b1;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            slot         <= slot_nxt;
            frame        <= frame_nxt;
            hold         <= hold_nxt;
            pending      <= pending_nxt;
            in_ready     <= ~pending_nxt;
            i2s_lrclk    <= lrclk_nxt;
            i2s_sdata    <= sdata_nxt;
            underrun_cnt <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized self-checking bench for audio_i2s_tx with a frame-level reference
// model and an I2S receiver that reassembles words on BCLK rising edges.
module tb_audio_i2s_tx;

    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned D        = 4;
    localparam int unsigned FRAME    = 64 * D;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [SAMPLE_W-1:0] in_sample;
    logic                in_valid;
    logic                in_ready;
    logic                i2s_bclk;
    logic                i2s_lrclk;
    logic                i2s_sdata;
    logic [7:0]          underrun_cnt;

    audio_i2s_tx #(
        .SAMPLE_W (SAMPLE_W),
        .BCLK_DIV (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state (edges counted since reset release).
    int                  e;
    bit                  m_pend;
    logic [SAMPLE_W-1:0] m_hold;
    logic [31:0]         m_word;
    int                  m_under;
    logic [31:0]         exp_q[$];

    // Source and receiver state.
    logic [SAMPLE_W-1:0] src_q[$];
    int                  mode;
    bit                  v_prev;
    int                  r;
    bit                  prev_bclk;
    logic [31:0]         asm_word;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Offset-binary to signed, scaled to 16 bits; both channels equal.
    function automatic logic [31:0] conv(input logic [SAMPLE_W-1:0] u);
        int s;
        logic [15:0] v;
        s = int'(u) - (1 << (SAMPLE_W - 1));
        v = 16'(s * (1 << (16 - SAMPLE_W)));
        return {v, v};
    endfunction

    function automatic bit is_load(input int edge_i);
        return (edge_i >= int'(2 * D)) && (((edge_i - int'(2 * D)) % int'(FRAME)) == 0);
    endfunction

    task automatic model_reset();
        e = 0; m_pend = 0; m_hold = '0; m_word = '0; m_under = 0;
        exp_q.delete();
        r = 0; prev_bclk = 0; asm_word = '0; v_prev = 0;
    endtask

    // Called at a negedge with e edges applied: check, drive edge e+1, advance.
    task automatic step();
        bit ld, gate, v, acc;
        logic [31:0] w;
        check_eq("bclk",  32'(i2s_bclk),  32'((e / int'(D)) % 2));
        check_eq("lrclk", 32'(i2s_lrclk), 32'(((e / int'(2 * D)) % 32) >= 16));
        check_eq("ready", 32'(in_ready),  32'(!m_pend));
        if (i2s_bclk && !prev_bclk) begin
            if (r == 0) begin
                check_eq("sdata_pre", 32'(i2s_sdata), 32'(0));
            end else begin
                asm_word = {asm_word[30:0], i2s_sdata};
                if (r % 32 == 0) begin
                    check_eq("word_avail", 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check_eq("frame_word", asm_word, w);
                    end
                    check_eq("underrun", 32'(underrun_cnt), 32'(m_under));
                end
            end
            r++;
        end
        prev_bclk = i2s_bclk;

        ld = is_load(e + 1);
        case (mode)
            0:       gate = 1'b1;
            1:       gate = ($urandom_range(0, 2) == 0);
            default: gate = ld;
        endcase
        v = (src_q.size() > 0) && (gate || v_prev);
        in_valid  = v;
        in_sample = v ? src_q[0] : SAMPLE_W'($urandom);
        acc = 1'b0;
        if (ld) begin
            if (m_pend) begin
                m_word = conv(m_hold);
                m_pend = 0;
            end else if (v) begin
                m_word = conv(src_q[0]);
                acc = 1'b1;
            end else if (m_under < 255) begin
                m_under++;
            end
            exp_q.push_back(m_word);
        end else if (v && !m_pend) begin
            m_hold = src_q[0];
            m_pend = 1;
            acc = 1'b1;
        end
        if (acc) void'(src_q.pop_front());
        v_prev = v && !acc;
        e++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_bclk",  32'(i2s_bclk),     32'(0));
        check_eq("rst_lrclk", 32'(i2s_lrclk),    32'(0));
        check_eq("rst_sdata", 32'(i2s_sdata),    32'(0));
        check_eq("rst_under", 32'(underrun_cnt), 32'(0));
        check_eq("rst_ready", 32'(in_ready),     32'(1));
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_phase(input int md, input bit rnd, input logic [SAMPLE_W-1:0] val,
                             input int n_samples, input int n_cycles);
        mode = md;
        src_q.delete();
        v_prev = 0;
        for (int i = 0; i < n_samples; i++)
            src_q.push_back(rnd ? SAMPLE_W'($urandom_range(0, (1 << SAMPLE_W) - 1)) : val);
        for (int i = 0; i < n_cycles; i++) step();
    endtask

    initial begin
        bit found;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        mode      = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Midpoint, full scale positive and negative, always-valid source.
        run_phase(0, 0, SAMPLE_W'(10'h200), 5, 3 * FRAME);
        check_eq("under_mid", 32'(underrun_cnt), 32'(0));
        run_phase(0, 0, SAMPLE_W'(10'h3FF), 4, 2 * FRAME);
        run_phase(0, 0, SAMPLE_W'(10'h000), 4, 2 * FRAME);

        // Reset in slot 20 of a frame.
        found = 0;
        for (int i = 0; i < int'(2 * FRAME) && !found; i++) begin
            if (e > int'(2 * D) && ((e / int'(2 * D)) % 32) == 20) found = 1;
            else step();
        end
        check_eq("reach_slot20", 32'(found), 32'(1));
        apply_reset();

        // One sample then starvation for three frames.
        run_phase(0, 0, SAMPLE_W'(10'h300), 1, 4 * FRAME + D + 2);
        check_eq("under_starve", 32'(underrun_cnt), 32'(3));

        // Back-to-back random samples, load-cycle-only bypass, random traffic.
        run_phase(0, 1, '0, 8, 3 * FRAME);
        run_phase(2, 0, SAMPLE_W'(10'h100), 4, 3 * FRAME);
        run_phase(1, 1, '0, 40, 8 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
